// File: rtl/calc_key_sequencer_if.sv
// rtl/calc_key_sequencer_if.sv - key sequencer bus bundle (oct_mode present only with CALC_OCTAL_EN)
interface calc_key_sequencer_if #(
  parameter int N_DIGITS = 4
);
  localparam int W = 4 * N_DIGITS;

  // cursor / ALU side inputs to the sequencer
  logic         select;
  logic [4:0]   val;
  logic [W-1:0] result;
`ifdef CALC_OCTAL_EN
  logic         oct_mode;
`endif

  // sequencer outputs
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [2:0]   op_sel;
  logic         exe;
  logic [W-1:0] display;
  logic         restriction;
  logic [1:0]   state;

  // environment side: cursor, ALU and display
  modport master (
`ifdef CALC_OCTAL_EN
    output oct_mode,
`endif
    output select, val, result,
    input  operand_a, operand_b, op_sel, exe, display, restriction, state
  );

  // sequencer side
  modport slave (
`ifdef CALC_OCTAL_EN
    input  oct_mode,
`endif
    input  select, val, result,
    output operand_a, operand_b, op_sel, exe, display, restriction, state
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - hex calculator key entry FSM (octal entry guarded by CALC_OCTAL_EN)
module calc_key_sequencer #(
  parameter int N_DIGITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  calc_key_sequencer_if.slave  bus
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(N_DIGITS);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_select_d;
  logic [W-1:0]  r_operand_a;
  logic [W-1:0]  r_operand_b;
  logic [2:0]    r_op_sel;
  logic          r_exe;
  logic [CW-1:0] r_count_a;
  logic [CW-1:0] r_count_b;

  logic          w_press;
  logic [3:0]    w_digit;
  logic          w_digit_ok;
  logic          w_is_digit;
  logic          w_is_op;
  logic [2:0]    w_op_code;
  logic          w_is_exe;
  logic          w_is_ce;
  logic          w_is_clr;
  logic [W-1:0]  w_display;

  assign w_press = bus.select && !r_select_d;
  assign w_digit = bus.val[3:0];

`ifdef CALC_OCTAL_EN
  // Octal mode refuses 8-F even if the cursor somehow lands on one.
  assign w_digit_ok      = !(bus.oct_mode && w_digit[3]);
  assign bus.restriction = bus.oct_mode;
`else
  assign w_digit_ok      = 1'b1;
  assign bus.restriction = 1'b0;
`endif

  assign w_is_digit = !bus.val[4] && w_digit_ok;
  assign w_is_exe   = (bus.val == 5'h13);
  assign w_is_ce    = (bus.val == 5'h16);
  assign w_is_clr   = (bus.val == 5'h17);

  // Map operator key codes onto the ALU op_sel encoding.
  always_comb begin
    w_is_op   = 1'b1;
    w_op_code = 3'd0;
    case (bus.val)
      5'h10:   w_op_code = 3'd0;
      5'h14:   w_op_code = 3'd1;
      5'h11:   w_op_code = 3'd2;
      5'h12:   w_op_code = 3'd3;
      5'h15:   w_op_code = 3'd4;
      default: w_is_op   = 1'b0;
    endcase
  end

  // Entry FSM: one key code acted on per select rising edge; exe is a registered one-cycle strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_A;
      r_select_d  <= 1'b0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_op_sel    <= 3'd0;
      r_exe       <= 1'b0;
      r_count_a   <= '0;
      r_count_b   <= '0;
    end else begin
      r_select_d <= bus.select;
      r_exe      <= 1'b0;
      if (w_press) begin
        if (w_is_clr) begin
          // select_d keeps tracking select so a held CLR press is not seen twice.
          r_state     <= S_A;
          r_operand_a <= '0;
          r_operand_b <= '0;
          r_op_sel    <= 3'd0;
          r_count_a   <= '0;
          r_count_b   <= '0;
        end else begin
          case (r_state)
            S_A: begin
              if (w_is_digit) begin
                if (r_count_a < MAX_CNT) begin
                  r_operand_a <= {r_operand_a[W-5:0], w_digit};
                  r_count_a   <= r_count_a + CW'(1);
                end
              end else if (w_is_op) begin
                // An empty operand A simply enters the operation as zero.
                r_op_sel    <= w_op_code;
                r_operand_b <= '0;
                r_count_b   <= '0;
                r_state     <= S_B;
              end else if (w_is_ce) begin
                r_operand_a <= '0;
                r_count_a   <= '0;
              end
            end
            S_B: begin
              if (w_is_digit) begin
                if (r_count_b < MAX_CNT) begin
                  r_operand_b <= {r_operand_b[W-5:0], w_digit};
                  r_count_b   <= r_count_b + CW'(1);
                end
              end else if (w_is_op) begin
                r_op_sel <= w_op_code;
              end else if (w_is_exe) begin
                r_exe   <= 1'b1;
                r_state <= S_RES;
              end else if (w_is_ce) begin
                r_operand_b <= '0;
                r_count_b   <= '0;
              end
            end
            S_RES: begin
              if (w_is_digit) begin
                r_operand_a <= {{(W-4){1'b0}}, w_digit};
                r_count_a   <= CW'(1);
                r_operand_b <= '0;
                r_count_b   <= '0;
                r_state     <= S_A;
              end else if (w_is_op) begin
                // Chain: the previous result becomes operand A of the new operation.
                r_operand_a <= bus.result;
                r_op_sel    <= w_op_code;
                r_operand_b <= '0;
                r_count_b   <= '0;
                r_state     <= S_B;
              end else if (w_is_ce) begin
                r_operand_a <= '0;
                r_operand_b <= '0;
                r_count_a   <= '0;
                r_count_b   <= '0;
                r_state     <= S_A;
              end
            end
            default: r_state <= S_A;
          endcase
        end
      end
    end
  end

  // Display follows the operand being edited; S_B shows A until B gets its first digit.
  always_comb begin
    w_display = r_operand_a;
    case (r_state)
      S_A:     w_display = r_operand_a;
      S_B:     w_display = (r_count_b != '0) ? r_operand_b : r_operand_a;
      S_RES:   w_display = bus.result;
      default: w_display = r_operand_a;
    endcase
  end

  assign bus.operand_a = r_operand_a;
  assign bus.operand_b = r_operand_b;
  assign bus.op_sel    = r_op_sel;
  assign bus.exe       = r_exe;
  assign bus.display   = w_display;
  assign bus.state     = r_state;
endmodule
